// File: rtl/gemm_ctrl_pkg.sv
// Shared widths and the issue-tag record for the GEMM issue controller.
package gemm_ctrl_pkg;

    localparam int ELEM_W           = 32;
    localparam int MAT_W            = 128;
    localparam int CORE_LAT_DEFAULT = 6;
    localparam int NUM_REQ_DEFAULT  = 4;
    localparam int ID_W             = $clog2(NUM_REQ_DEFAULT);

    // One entry of the tag pipe that shadows the core pipeline.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/gemm_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer; the pointer moves past the
// granted index only when the caller strobes advance.
module gemm_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx_hi;
    logic [IDX_W-1:0] idx_lo;
    logic             found_hi;
    logic             found_lo;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        found_hi  = 1'b0;
        found_lo  = 1'b0;
        idx_hi    = '0;
        idx_lo    = '0;
        grant     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) >= ptr)) begin
                found_hi = 1'b1;
                idx_hi   = IDX_W'(i);
            end
            if (req[i]) begin
                found_lo = 1'b1;
                idx_lo   = IDX_W'(i);
            end
        end
        grant_idx = found_hi ? idx_hi : idx_lo;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = found_lo && (grant_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/gemm_issue_ctrl.sv
// Issue scheduler for the fixed-latency 2x2 GEMM core with credit-guarded result FIFO.
// Optional statistics counters are built when GEMM_ISSUE_CTRL_STATS_EN is defined.
module gemm_issue_ctrl
    import gemm_ctrl_pkg::*;
#(
    parameter  int NUM_REQ    = NUM_REQ_DEFAULT,
    parameter  int FIFO_DEPTH = 8,
    parameter  int CORE_LAT   = CORE_LAT_DEFAULT,
    localparam int IDW        = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*MAT_W-1:0] req_a,
    input  logic [NUM_REQ*MAT_W-1:0] req_b,
    output logic [MAT_W-1:0]         core_a,
    output logic [MAT_W-1:0]         core_b,
    input  logic [MAT_W-1:0]         core_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [MAT_W-1:0]         res_data,
    output logic [IDW-1:0]           res_id,
    output logic                     busy
`ifdef GEMM_ISSUE_CTRL_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_stall
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready depends combinationally on req_valid (the grant) and the credit count;
    // res_valid depends only on FIFO state, never on res_ready.

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               can_issue;
    logic               issue;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    tag_t               tags [CORE_LAT];
    logic [MAT_W-1:0]   data_mem [FIFO_DEPTH];
    logic [IDW-1:0]     id_mem [FIFO_DEPTH];

    gemm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (issue),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign can_issue = (outstanding < CNT_W'(FIFO_DEPTH));
    assign req_ready = grant & {NUM_REQ{can_issue}};
    assign issue     = |(req_valid & req_ready);
    assign push      = tags[CORE_LAT-1].valid;
    assign pop       = res_valid && res_ready;

    // The core sees zeros whenever nothing issues, so idle cycles are recognisable.
    always_comb begin
        core_a = '0;
        core_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue && grant[i]) begin
                core_a = req_a[i*MAT_W +: MAT_W];
                core_b = req_b[i*MAT_W +: MAT_W];
            end
        end
    end

    // The last tag stage lines up with core_out; a valid tag there means capture next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < CORE_LAT; s++) begin
                tags[s] <= '0;
            end
        end else begin
            tags[0] <= '{valid: issue, id: ID_W'(grant_idx)};
            for (int s = 1; s < CORE_LAT; s++) begin
                tags[s] <= tags[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= core_out;
            id_mem[wr_ptr]   <= IDW'(tags[CORE_LAT-1].id);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            // A credit is held from issue until the result leaves the FIFO.
            if (issue && !pop) begin
                outstanding <= outstanding + 1'b1;
            end else if (!issue && pop) begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

    assign res_valid = (count != '0);
    assign res_data  = res_valid ? data_mem[rd_ptr] : '0;
    assign res_id    = res_valid ? id_mem[rd_ptr] : '0;
    assign busy      = (outstanding != '0);

`ifdef GEMM_ISSUE_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue && (stat_issued != '1)) stat_issued <= stat_issued + 32'd1;
            if ((|req_valid) && !can_issue && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule
